// File: rtl/mru_step_sequencer_pkg.sv
// Shared definitions for the MRU blocked-step sequencer.
// Holds the sequencer FSM state encoding and the bit offsets of the
// {count_minus_one, opcode} instruction word.
package mru_step_sequencer_pkg;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } mru_seq_state_e;

    // The opcode occupies the least significant bits of the instruction word.
    localparam int unsigned INST_OPCODE_LSB = 0;

    // The count_minus_one field sits directly above the opcode.
    function automatic int unsigned inst_count_lsb(input int unsigned bw_opcode);
        return bw_opcode;
    endfunction

endpackage

// File: rtl/mru_inst_fifo.sv
// Instruction buffer for the MRU step sequencer.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   clear        - synchronous flush (empties the buffer, pointers to 0)
//   push, wdata  - write request and data (ignored while full)
//   pop          - release the head entry (ignored while empty)
//   rdata        - head entry
//   full, empty  - status from the registered occupancy
module mru_inst_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (count_q == DEPTH_CNT);
    assign empty     = (count_q == '0);
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign rdata     = mem_q[rd_ptr_q];

    // Storage array write port; contents are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (do_push_s && !rst && !clear) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointer and occupancy update; reset and clear both empty the buffer.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (do_pop_s) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mru_step_sequencer.sv
// MRU step sequencer: buffers {count_minus_one, opcode} instructions and
// expands each into count_minus_one+1 blocked steps {last, opcode} offered
// to the MRU, then waits for the MRU completion pulse before the next one.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   clear             - synchronous flush of buffer and FSM
//   inst_valid/inst   - instruction offer; inst_ready = buffer not full
//   step_valid/inst   - registered step offer; step_ready from the MRU
//   mru_done          - MRU completion pulse (honoured only in WAIT_DONE)
//   inst_done         - one-cycle pulse per completed instruction
//   busy              - buffer non-empty or FSM not idle
//   steps_remaining   - steps left after the currently offered one
module mru_step_sequencer
    import mru_step_sequencer_pkg::*;
#(
    parameter int unsigned BW_OPCODE     = 4,
    parameter int unsigned BW_STEP_COUNT = 8,
    parameter int unsigned FIFO_DEPTH    = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic                             inst_valid,
    input  logic [BW_STEP_COUNT+BW_OPCODE-1:0] inst,
    output logic                             inst_ready,
    output logic                             step_valid,
    output logic [BW_OPCODE:0]               step_inst,
    input  logic                             step_ready,
    input  logic                             mru_done,
    output logic                             inst_done,
    output logic                             busy,
    output logic [BW_STEP_COUNT-1:0]         steps_remaining
);

    localparam int unsigned INST_W  = BW_STEP_COUNT + BW_OPCODE;
    localparam int unsigned CNT_LSB = inst_count_lsb(BW_OPCODE);

    mru_seq_state_e           state_q, state_d;
    logic [BW_OPCODE-1:0]     opcode_q, opcode_d;
    logic [BW_STEP_COUNT-1:0] remaining_q, remaining_d;
    logic                     step_valid_q, step_valid_d;
    logic [BW_OPCODE:0]       step_inst_q, step_inst_d;

    logic [INST_W-1:0]        fifo_rdata_s;
    logic                     fifo_full_s;
    logic                     fifo_empty_s;
    logic                     fifo_push_s;
    logic                     fifo_pop_s;
    logic [BW_OPCODE-1:0]     head_opcode_s;
    logic [BW_STEP_COUNT-1:0] head_count_s;

    assign head_opcode_s = fifo_rdata_s[INST_OPCODE_LSB +: BW_OPCODE];
    assign head_count_s  = fifo_rdata_s[CNT_LSB +: BW_STEP_COUNT];

    assign inst_ready  = ~fifo_full_s;
    assign fifo_push_s = inst_valid & inst_ready & ~clear;
    // The head stays buffered while its steps issue and leaves with the last one.
    assign fifo_pop_s  = (state_q == ST_ISSUE) & step_ready
                       & (remaining_q == '0) & ~clear;

    mru_inst_fifo #(
        .WIDTH (INST_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .wdata (inst),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next-state and next-output computation for the sequencer FSM.
    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        remaining_d  = remaining_q;
        step_valid_d = step_valid_q;
        step_inst_d  = step_inst_q;
        if (clear) begin
            state_d      = ST_IDLE;
            opcode_d     = '0;
            remaining_d  = '0;
            step_valid_d = 1'b0;
            step_inst_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        state_d      = ST_ISSUE;
                        opcode_d     = head_opcode_s;
                        remaining_d  = head_count_s;
                        step_valid_d = 1'b1;
                        step_inst_d  = {head_count_s == '0, head_opcode_s};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (step_ready && (remaining_q != '0)) begin
                        remaining_d = remaining_q - BW_STEP_COUNT'(1);
                        step_inst_d = {remaining_q == BW_STEP_COUNT'(1), opcode_q};
                    end else if (step_ready) begin
                        state_d      = ST_WAIT_DONE;
                        step_valid_d = 1'b0;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (mru_done && !fifo_empty_s) begin
                        state_d      = ST_ISSUE;
                        opcode_d     = head_opcode_s;
                        remaining_d  = head_count_s;
                        step_valid_d = 1'b1;
                        step_inst_d  = {head_count_s == '0, head_opcode_s};
                    end else if (mru_done) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_DONE;
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    opcode_d     = '0;
                    remaining_d  = '0;
                    step_valid_d = 1'b0;
                    step_inst_d  = '0;
                end
            endcase
        end
    end

    // Sequencer state and registered step outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            opcode_q     <= '0;
            remaining_q  <= '0;
            step_valid_q <= 1'b0;
            step_inst_q  <= '0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            remaining_q  <= remaining_d;
            step_valid_q <= step_valid_d;
            step_inst_q  <= step_inst_d;
        end
    end

    assign step_valid      = step_valid_q;
    assign step_inst       = step_inst_q;
    assign steps_remaining = remaining_q;
    // A completion pulse is only meaningful while waiting; reset and clear mask it.
    assign inst_done = (state_q == ST_WAIT_DONE) & mru_done & ~clear & ~rst;
    assign busy      = (state_q != ST_IDLE) | ~fifo_empty_s;

endmodule

// File: tb/tb_mru_step_sequencer.sv
// Self-checking bench for mru_step_sequencer (default parameters:
// 4-bit opcode, 8-bit count, 2-entry buffer).
module tb_mru_step_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        inst_valid;
    logic [11:0] inst;
    logic        inst_ready;
    logic        step_valid;
    logic [4:0]  step_inst;
    logic        step_ready;
    logic        mru_done;
    logic        inst_done;
    logic        busy;
    logic [7:0]  steps_remaining;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mru_step_sequencer #(
        .BW_OPCODE     (4),
        .BW_STEP_COUNT (8),
        .FIFO_DEPTH    (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .clear           (clear),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_ready      (inst_ready),
        .step_valid      (step_valid),
        .step_inst       (step_inst),
        .step_ready      (step_ready),
        .mru_done        (mru_done),
        .inst_done       (inst_done),
        .busy            (busy),
        .steps_remaining (steps_remaining)
    );

    typedef struct packed {
        logic       iv;
        logic [11:0] ins;
        logic       sr;
        logic       md;
        logic       sv;
        logic [4:0] si;
        logic       done;
        logic       rdy;
        logic       bsy;
        logic [7:0] rem;
    } vec_t;

    typedef struct packed {
        logic [4:0] si;
        logic [7:0] rem;
    } step_t;

    vec_t  tbl [12];
    step_t exp_q [$];
    int    occ;
    bit    pending;
    int    accepted;
    int    completed;
    bit    prev_stall;
    logic [4:0] prev_si;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [11:0] ins, input logic sr,
                         input logic md, input logic clr);
        inst_valid = iv;
        inst       = ins;
        step_ready = sr;
        mru_done   = md;
        clear      = clr;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // One cycle of the randomised scoreboard: the model tracks buffer
    // occupancy, the expected step stream and whether a completion is owed.
    task automatic rnd_cycle(input logic iv, input logic [11:0] ins,
                             input logic sr, input logic md);
        bit    pop_now;
        bit    done_now;
        step_t e;
        drive(iv, ins, sr, md, 1'b0);
        chk("rnd_ready", 32'(inst_ready), 32'(occ < 2));
        chk("rnd_busy", 32'(busy), 32'((occ != 0) || pending));
        done_now = pending && md;
        chk("rnd_done", 32'(inst_done), 32'(done_now));
        if (pending) chk("rnd_no_step_in_wait", 32'(step_valid), 32'd0);
        if (prev_stall) begin
            chk("rnd_hold_valid", 32'(step_valid), 32'd1);
            chk("rnd_hold_inst", 32'(step_inst), 32'(prev_si));
        end
        pop_now = 1'b0;
        if (step_valid && sr) begin
            if (exp_q.size() == 0) begin
                chk("rnd_unexpected_step", 32'(step_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rnd_step_inst", 32'(step_inst), 32'(e.si));
                chk("rnd_step_rem", 32'(steps_remaining), 32'(e.rem));
                pop_now = e.si[4];
            end
        end
        prev_stall = step_valid && !sr;
        prev_si    = step_inst;
        if (iv && (occ < 2)) begin
            for (int k = int'(ins[11:4]); k >= 0; k--) begin
                e.si  = {k == 0, ins[3:0]};
                e.rem = 8'(k);
                exp_q.push_back(e);
            end
            occ++;
            accepted++;
        end
        if (done_now) begin
            pending = 1'b0;
            completed++;
        end
        if (pop_now) begin
            occ--;
            pending = 1'b1;
        end
        adv();
    endtask

    initial begin
        bit drained;
        rst = 1'b1;
        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        repeat (3) adv();
        rst = 1'b0;

        // Reset values.
        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        chk("reset_ready", 32'(inst_ready), 32'd1);
        chk("reset_valid", 32'(step_valid), 32'd0);
        chk("reset_inst", 32'(step_inst), 32'd0);
        chk("reset_done", 32'(inst_done), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rem", 32'(steps_remaining), 32'd0);
        adv();

        // Single 3-step instruction, then mru_done 4 cycles after the last step,
        // then mru_done while idle.
        tbl[0]  = '{1'b1, {8'd2, 4'h5}, 1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 12'h000,      1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 1'b1, 1'b1, 8'd0};
        tbl[2]  = '{1'b0, 12'h000,      1'b1, 1'b0, 1'b1, 5'h05, 1'b0, 1'b1, 1'b1, 8'd2};
        tbl[3]  = '{1'b0, 12'h000,      1'b1, 1'b0, 1'b1, 5'h05, 1'b0, 1'b1, 1'b1, 8'd1};
        tbl[4]  = '{1'b0, 12'h000,      1'b1, 1'b0, 1'b1, 5'h15, 1'b0, 1'b1, 1'b1, 8'd0};
        tbl[5]  = '{1'b0, 12'h000,      1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 1'b1, 1'b1, 8'd0};
        tbl[6]  = tbl[5];
        tbl[7]  = tbl[5];
        tbl[8]  = '{1'b0, 12'h000,      1'b1, 1'b1, 1'b0, 5'h00, 1'b1, 1'b1, 1'b1, 8'd0};
        tbl[9]  = '{1'b0, 12'h000,      1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[10] = '{1'b0, 12'h000,      1'b1, 1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[11] = tbl[9];
        for (int r = 0; r < 12; r++) begin
            drive(tbl[r].iv, tbl[r].ins, tbl[r].sr, tbl[r].md, 1'b0);
            chk($sformatf("tbl%0d_valid", r), 32'(step_valid), 32'(tbl[r].sv));
            if (tbl[r].sv) chk($sformatf("tbl%0d_inst", r), 32'(step_inst), 32'(tbl[r].si));
            chk($sformatf("tbl%0d_done", r), 32'(inst_done), 32'(tbl[r].done));
            chk($sformatf("tbl%0d_ready", r), 32'(inst_ready), 32'(tbl[r].rdy));
            chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].bsy));
            chk($sformatf("tbl%0d_rem", r), 32'(steps_remaining), 32'(tbl[r].rem));
            adv();
        end

        // Back-pressure on the middle step.
        drive(1'b1, {8'd2, 4'hA}, 1'b0, 1'b0, 1'b0); adv();
        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        chk("stall_pre_valid", 32'(step_valid), 32'd0); adv();
        drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        chk("stall_s0_inst", 32'(step_inst), 32'h0A);
        chk("stall_s0_rem", 32'(steps_remaining), 32'd2); adv();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
            chk("stall_hold_valid", 32'(step_valid), 32'd1);
            chk("stall_hold_inst", 32'(step_inst), 32'h0A);
            chk("stall_hold_rem", 32'(steps_remaining), 32'd1);
            adv();
        end
        drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        chk("stall_s1_rem", 32'(steps_remaining), 32'd1); adv();
        drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        chk("stall_s2_valid", 32'(step_valid), 32'd1);
        chk("stall_s2_inst", 32'(step_inst), 32'h1A); adv();
        drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        chk("stall_no_dup", 32'(step_valid), 32'd0); adv();
        drive(1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
        chk("stall_done", 32'(inst_done), 32'd1); adv();
        drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        chk("stall_idle_busy", 32'(busy), 32'd0); adv();

        // Three single-step instructions with completion withheld.
        drive(1'b1, {8'd0, 4'h1}, 1'b1, 1'b0, 1'b0);
        chk("b2b_rdy0", 32'(inst_ready), 32'd1); adv();
        drive(1'b1, {8'd0, 4'h2}, 1'b1, 1'b0, 1'b0);
        chk("b2b_rdy1", 32'(inst_ready), 32'd1); adv();
        drive(1'b1, {8'd0, 4'h3}, 1'b1, 1'b0, 1'b0);
        chk("b2b_full", 32'(inst_ready), 32'd0);
        chk("b2b_a_inst", 32'(step_inst), 32'h11); adv();
        drive(1'b1, {8'd0, 4'h3}, 1'b1, 1'b0, 1'b0);
        chk("b2b_rdy3", 32'(inst_ready), 32'd1);
        chk("b2b_wait_valid", 32'(step_valid), 32'd0); adv();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
            chk("b2b_full2", 32'(inst_ready), 32'd0);
            chk("b2b_withheld_done", 32'(inst_done), 32'd0);
            adv();
        end
        drive(1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
        chk("b2b_done_a", 32'(inst_done), 32'd1); adv();
        drive(1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
        chk("b2b_b_valid", 32'(step_valid), 32'd1);
        chk("b2b_b_inst", 32'(step_inst), 32'h12);
        chk("b2b_done_in_issue", 32'(inst_done), 32'd0); adv();
        drive(1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
        chk("b2b_done_b", 32'(inst_done), 32'd1); adv();
        drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        chk("b2b_c_inst", 32'(step_inst), 32'h13); adv();
        drive(1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
        chk("b2b_done_c", 32'(inst_done), 32'd1); adv();
        drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        chk("b2b_idle_busy", 32'(busy), 32'd0); adv();

        // Clear while issuing with a buffered instruction behind.
        drive(1'b1, {8'd5, 4'h7}, 1'b0, 1'b0, 1'b0); adv();
        drive(1'b1, {8'd0, 4'h3}, 1'b0, 1'b0, 1'b0); adv();
        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
        chk("clr_pre_rem", 32'(steps_remaining), 32'd5);
        chk("clr_pre_ready", 32'(inst_ready), 32'd0); adv();
        drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        chk("clr_valid", 32'(step_valid), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_ready", 32'(inst_ready), 32'd1);
        chk("clr_rem", 32'(steps_remaining), 32'd0); adv();
        drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        chk("clr_stays_idle", 32'(step_valid), 32'd0); adv();
        drive(1'b1, {8'd0, 4'h9}, 1'b1, 1'b0, 1'b1); adv();
        drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        chk("clr_push_dropped", 32'(busy), 32'd0); adv();
        drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        chk("clr_push_no_step", 32'(step_valid), 32'd0); adv();

        // Reset while waiting for completion, with one instruction buffered.
        drive(1'b1, {8'd0, 4'h4}, 1'b1, 1'b0, 1'b0); adv();
        drive(1'b1, {8'd0, 4'h6}, 1'b1, 1'b0, 1'b0); adv();
        drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        chk("rst_pre_inst", 32'(step_inst), 32'h14); adv();
        rst = 1'b1;
        drive(1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
        chk("rst_no_done", 32'(inst_done), 32'd0); adv();
        rst = 1'b0;
        drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        chk("rst_ready", 32'(inst_ready), 32'd1);
        chk("rst_valid", 32'(step_valid), 32'd0);
        chk("rst_inst", 32'(step_inst), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rem", 32'(steps_remaining), 32'd0); adv();
        drive(1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
        chk("rst_late_done", 32'(inst_done), 32'd0); adv();
        drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        chk("rst_discarded", 32'(step_valid), 32'd0); adv();

        // Randomised traffic against the transaction-level model.
        occ = 0; pending = 1'b0; accepted = 0; completed = 0; prev_stall = 1'b0; prev_si = 5'h00;
        for (int c = 0; c < 3000; c++) begin
            rnd_cycle($urandom_range(0, 1) == 1,
                      {8'($urandom_range(0, 3)), 4'($urandom_range(0, 15))},
                      $urandom_range(0, 9) < 7,
                      $urandom_range(0, 3) == 0);
        end
        drained = 1'b0;
        for (int c = 0; c < 400 && !drained; c++) begin
            rnd_cycle(1'b0, 12'h000, 1'b1, 1'b1);
            drained = (exp_q.size() == 0) && !pending && (occ == 0);
        end
        chk("rnd_drain_timeout", 32'(drained), 32'd1);
        chk("rnd_all_completed", 32'(completed), 32'(accepted));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
